// File: rtl/tod_ctrl_if.sv
// Register/tick bus between the register-file decode and the time-of-day controller.
// Master drives tick, configuration and register strobes; slave returns read data and the alarm pulse.
interface tod_ctrl_if;
  logic       tick;
  logic       sel50;
  logic       alarm_sel;
  logic       we;
  logic       re;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       alarm_irq;

  modport master (
    output tick, sel50, alarm_sel, we, re, addr, wdata,
    input  rdata, alarm_irq
  );

  modport slave (
    input  tick, sel50, alarm_sel, we, re, addr, wdata,
    output rdata, alarm_irq
  );
endinterface

// File: rtl/tod_ctrl.sv
// BCD time-of-day counter: prescaled 50/60 Hz tick, one-edge ripple carry, CPU write arbitration, hours read latch.
// Alarm storage, comparator and alarm_irq exist only when TOD_ALARM_EN is defined; otherwise alarm_irq is 0.
module tod_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  tod_ctrl_if.slave  bus
);

  // Digits are held as full read-back bytes with unused bits forced to 0 by the write masks.
  localparam logic [7:0] TEN_MASK = 8'h0F;
  localparam logic [7:0] SEC_MASK = 8'h7F;
  localparam logic [7:0] MIN_MASK = 8'h7F;
  localparam logic [7:0] HR_MASK  = 8'h9F;

  logic [7:0] ten_q, sec_q, min_q, hr_q;
  logic [7:0] ten_d, sec_d, min_d, hr_d;
  logic [7:0] lat_ten_q, lat_sec_q, lat_min_q, lat_hr_q;
  logic [2:0] presc_q, presc_d;
  logic       running_q, running_d;
  logic       latched_q, latched_d;
  logic       capture;

  logic [2:0] term;
  logic       tick_en;
  logic       inc;
  logic       wr_time;
  logic [3:0] wr;
  logic       c_sec, c_min, c_hr;

  function automatic logic [7:0] inc_ten(input logic [7:0] v);
    if (v[3:0] == 4'd9) inc_ten = 8'h00;
    else                inc_ten = {4'h0, v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_60(input logic [7:0] v);
    if (v[3:0] != 4'd9)       inc_60 = {1'b0, v[6:4], v[3:0] + 4'd1};
    else if (v[6:4] == 3'd5)  inc_60 = 8'h00;
    else                      inc_60 = {1'b0, v[6:4] + 3'd1, 4'h0};
  endfunction

  // 11 -> 12 flips AM/PM; 12 -> 01 keeps it.
  function automatic logic [7:0] inc_hr(input logic [7:0] v);
    logic pm;
    pm = v[7];
    if (v[4:0] == 5'h11)       inc_hr = {~pm, 2'b00, 5'h12};
    else if (v[4:0] == 5'h12)  inc_hr = {pm, 2'b00, 5'h01};
    else if (v[3:0] == 4'd9)   inc_hr = {pm, 2'b00, 5'h10};
    else                       inc_hr = {pm, 2'b00, v[4], v[3:0] + 4'd1};
  endfunction

  assign term    = bus.sel50 ? 3'd4 : 3'd5;
  assign tick_en = bus.tick && running_q;
  assign inc     = tick_en && (presc_q == term);
  assign wr_time = bus.we && !bus.alarm_sel;

  always_comb begin
    wr = 4'b0000;
    if (wr_time) wr[bus.addr] = 1'b1;
  end

  // A written digit takes wdata and swallows its incoming carry; its own carry-out is 0.
  always_comb begin
    ten_d = ten_q;
    c_sec = 1'b0;
    if (wr[0]) begin
      ten_d = bus.wdata & TEN_MASK;
    end else if (inc) begin
      ten_d = inc_ten(ten_q);
      c_sec = (ten_q[3:0] == 4'd9);
    end

    sec_d = sec_q;
    c_min = 1'b0;
    if (wr[1]) begin
      sec_d = bus.wdata & SEC_MASK;
    end else if (c_sec) begin
      sec_d = inc_60(sec_q);
      c_min = (sec_q[6:0] == 7'h59);
    end

    min_d = min_q;
    c_hr  = 1'b0;
    if (wr[2]) begin
      min_d = bus.wdata & MIN_MASK;
    end else if (c_min) begin
      min_d = inc_60(min_q);
      c_hr  = (min_q[6:0] == 7'h59);
    end

    hr_d = hr_q;
    if (wr[3])     hr_d = bus.wdata & HR_MASK;
    else if (c_hr) hr_d = inc_hr(hr_q);
  end

  // A counter left above a shortened terminal by a sel50 change wraps without advancing tenths.
  always_comb begin
    presc_d = presc_q;
    if (wr[3]) begin
      presc_d = 3'd0;
    end else if (tick_en) begin
      if (presc_q >= term) presc_d = 3'd0;
      else                 presc_d = presc_q + 3'd1;
    end
  end

  always_comb begin
    running_d = running_q;
    if (wr[3])      running_d = 1'b0;
    else if (wr[0]) running_d = 1'b1;
  end

  always_comb begin
    capture   = bus.re && (bus.addr == 2'd3) && !latched_q;
    latched_d = latched_q;
    if (capture)                              latched_d = 1'b1;
    else if (bus.re && (bus.addr == 2'd0))    latched_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_q     <= 8'h00;
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hr_q      <= 8'h01;
      presc_q   <= 3'd0;
      running_q <= 1'b1;
      latched_q <= 1'b0;
      lat_ten_q <= 8'h00;
      lat_sec_q <= 8'h00;
      lat_min_q <= 8'h00;
      lat_hr_q  <= 8'h00;
    end else begin
      ten_q     <= ten_d;
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      latched_q <= latched_d;
      if (capture) begin
        lat_ten_q <= ten_q;
        lat_sec_q <= sec_q;
        lat_min_q <= min_q;
        lat_hr_q  <= hr_q;
      end
    end
  end

  always_comb begin
    bus.rdata = 8'h00;
    case (bus.addr)
      2'd0:    bus.rdata = latched_q ? lat_ten_q : ten_q;
      2'd1:    bus.rdata = latched_q ? lat_sec_q : sec_q;
      2'd2:    bus.rdata = latched_q ? lat_min_q : min_q;
      default: bus.rdata = latched_q ? lat_hr_q  : hr_q;
    endcase
  end

`ifdef TOD_ALARM_EN
  logic [7:0] al_ten_q, al_sec_q, al_min_q, al_hr_q;
  logic       match_q;
  logic       irq_q;
  logic       wr_alarm;
  logic       eq;

  assign wr_alarm = bus.we && bus.alarm_sel;
  assign eq       = (ten_q == al_ten_q) && (sec_q == al_sec_q) &&
                    (min_q == al_min_q) && (hr_q == al_hr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_ten_q <= 8'h00;
      al_sec_q <= 8'h00;
      al_min_q <= 8'h00;
      al_hr_q  <= 8'h00;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_alarm) begin
        case (bus.addr)
          2'd0:    al_ten_q <= bus.wdata & TEN_MASK;
          2'd1:    al_sec_q <= bus.wdata & SEC_MASK;
          2'd2:    al_min_q <= bus.wdata & MIN_MASK;
          default: al_hr_q  <= bus.wdata & HR_MASK;
        endcase
      end
      match_q <= eq;
      irq_q   <= eq && !match_q;
    end
  end

  assign bus.alarm_irq = irq_q;
`else
  assign bus.alarm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_tod_ctrl.sv
// Directed bench for tod_ctrl: counting, carries, write arbitration, read latch, reset, alarm.
module tb_tod_ctrl;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  tod_ctrl_if bus ();

  tod_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic r, input logic [7:0] exp, input string tag);
    bus.addr = a;
    bus.re   = r;
    #1;
    chk(tag, bus.rdata, exp);
    @(posedge clk);
    #1;
    bus.re = 1'b0;
  endtask

  task automatic wr(input logic as, input logic [1:0] a, input logic [7:0] d);
    bus.alarm_sel = as;
    bus.we        = 1'b1;
    bus.addr      = a;
    bus.wdata     = d;
    @(posedge clk);
    #1;
    bus.we        = 1'b0;
    bus.alarm_sel = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic [7:0] t);
    wr(1'b0, 2'd3, h);
    wr(1'b0, 2'd2, m);
    wr(1'b0, 2'd1, s);
    wr(1'b0, 2'd0, t);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst_n         = 1'b0;
    bus.tick      = 1'b0;
    bus.sel50     = 1'b0;
    bus.alarm_sel = 1'b0;
    bus.we        = 1'b0;
    bus.re        = 1'b0;
    bus.addr      = 2'd0;
    bus.wdata     = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    rd(2'd0, 1'b0, 8'h00, "rst_ten");
    rd(2'd1, 1'b0, 8'h00, "rst_sec");
    rd(2'd2, 1'b0, 8'h00, "rst_min");
    rd(2'd3, 1'b0, 8'h01, "rst_hr");
    chk("rst_irq", {7'd0, bus.alarm_irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 60 Hz: 60 ticks are one second
    ticks(60);
    rd(2'd0, 1'b0, 8'h00, "t60_ten");
    rd(2'd1, 1'b0, 8'h01, "t60_sec");
    rd(2'd3, 1'b0, 8'h01, "t60_hr");
    ticks(5);
    rd(2'd0, 1'b0, 8'h00, "presc_5");
    ticks(1);
    rd(2'd0, 1'b0, 8'h01, "presc_6");

    // full ripple 11:59:59.9 AM -> 12:00:00.0 PM
    set_time(8'h11, 8'h59, 8'h59, 8'h09);
    ticks(6);
    rd(2'd3, 1'b0, 8'h92, "rip_hr");
    rd(2'd2, 1'b0, 8'h00, "rip_min");
    rd(2'd1, 1'b0, 8'h00, "rip_sec");
    rd(2'd0, 1'b0, 8'h00, "rip_ten");

    // 12:59:59.9 PM -> 01:00:00.0 PM
    set_time(8'h92, 8'h59, 8'h59, 8'h09);
    ticks(6);
    rd(2'd3, 1'b0, 8'h81, "pm12_hr");
    rd(2'd2, 1'b0, 8'h00, "pm12_min");

    // hours write stops the clock (bits 6:5 masked), tenths write restarts it
    wr(1'b0, 2'd3, 8'h65);
    ticks(20);
    rd(2'd3, 1'b0, 8'h05, "stop_hr");
    rd(2'd0, 1'b0, 8'h00, "stop_ten");
    rd(2'd1, 1'b0, 8'h00, "stop_sec");
    wr(1'b0, 2'd0, 8'h00);
    ticks(6);
    rd(2'd0, 1'b0, 8'h01, "resume_ten");

    // read latch
    set_time(8'h01, 8'h00, 8'h00, 8'h09);
    rd(2'd3, 1'b1, 8'h01, "lat_hr");
    ticks(6);
    rd(2'd2, 1'b0, 8'h00, "lat_min");
    rd(2'd1, 1'b0, 8'h00, "lat_sec");
    rd(2'd3, 1'b0, 8'h01, "lat_hr2");
    rd(2'd0, 1'b1, 8'h09, "lat_ten");
    rd(2'd0, 1'b0, 8'h00, "live_ten");
    rd(2'd1, 1'b0, 8'h01, "live_sec");

    // tenths write on the same edge as a 9->0 increment
    wr(1'b0, 2'd0, 8'h09);
    ticks(5);
    bus.tick  = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 2'd0;
    bus.wdata = 8'h07;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.we   = 1'b0;
    rd(2'd0, 1'b0, 8'h07, "wrinc_ten");
    rd(2'd1, 1'b0, 8'h01, "wrinc_sec");

    // hours write on an increment edge: lower digits still carry, then frozen
    wr(1'b0, 2'd0, 8'h09);
    ticks(5);
    bus.tick  = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 2'd3;
    bus.wdata = 8'h03;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.we   = 1'b0;
    rd(2'd3, 1'b0, 8'h03, "hrinc_hr");
    rd(2'd0, 1'b0, 8'h00, "hrinc_ten");
    rd(2'd1, 1'b0, 8'h02, "hrinc_sec");
    ticks(6);
    rd(2'd0, 1'b0, 8'h00, "hrinc_frozen");

    // latch capture on an increment edge sees pre-edge time
    wr(1'b0, 2'd0, 8'h09);
    ticks(5);
    bus.tick = 1'b1;
    bus.re   = 1'b1;
    bus.addr = 2'd3;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    bus.re   = 1'b0;
    rd(2'd1, 1'b0, 8'h02, "relat_sec");
    rd(2'd0, 1'b1, 8'h09, "relat_ten");
    rd(2'd0, 1'b0, 8'h00, "relive_ten");
    rd(2'd1, 1'b0, 8'h03, "relive_sec");

    // reset while latched returns live reset values
    rd(2'd3, 1'b1, 8'h03, "prerst_hr");
    rst_n = 1'b0;
    #1;
    rd(2'd3, 1'b0, 8'h01, "rstlat_hr");
    rd(2'd1, 1'b0, 8'h00, "rstlat_sec");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef TOD_ALARM_EN
    wr(1'b1, 2'd3, 8'h01);
    wr(1'b1, 2'd1, 8'h01);
    rd(2'd1, 1'b0, 8'h00, "al_time_sec");
    rd(2'd3, 1'b0, 8'h01, "al_time_hr");
    ticks(59);
    rd(2'd0, 1'b0, 8'h09, "al_pre_ten");
    chk("al_pre_irq", {7'd0, bus.alarm_irq}, 8'h00);
    bus.tick = 1'b1;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
    chk("al_edge_irq", {7'd0, bus.alarm_irq}, 8'h00);
    bus.addr = 2'd1;
    #1;
    chk("al_edge_sec", bus.rdata, 8'h01);
    @(posedge clk);
    #1;
    chk("al_pulse", {7'd0, bus.alarm_irq}, 8'h01);
    @(posedge clk);
    #1;
    chk("al_pulse_end", {7'd0, bus.alarm_irq}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("al_norepeat", {7'd0, bus.alarm_irq}, 8'h00);
    end
    wr(1'b1, 2'd1, 8'h02);
    wr(1'b1, 2'd1, 8'h01);
    chk("alw_pre", {7'd0, bus.alarm_irq}, 8'h00);
    @(posedge clk);
    #1;
    chk("alw_pulse", {7'd0, bus.alarm_irq}, 8'h01);
    @(posedge clk);
    #1;
    chk("alw_end", {7'd0, bus.alarm_irq}, 8'h00);
`else
    wr(1'b1, 2'd0, 8'h05);
    rd(2'd0, 1'b0, 8'h00, "noal_ten");
    wr(1'b1, 2'd3, 8'h07);
    rd(2'd3, 1'b0, 8'h01, "noal_hr");
    ticks(6);
    rd(2'd0, 1'b0, 8'h01, "noal_run");
    chk("noal_irq", {7'd0, bus.alarm_irq}, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
